// File: rtl/controlo_pkg.sv
// Shared types and constants for the weighing controller (controlo_pesagem).
package controlo_pkg;

    typedef enum logic [1:0] {
        ACUMULA,
        DIVIDE,
        PUBLICA
    } estado_t;

    localparam int unsigned LARG_PESO      = 12;
    localparam int unsigned LIMITE_G_DEF   = 4000;
    localparam int unsigned JANELA_EST_DEF = 8;

    function automatic logic [LARG_PESO-1:0] dif_abs(input logic [LARG_PESO-1:0] a,
                                                     input logic [LARG_PESO-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/media_amostras.sv
// Accumulates N_AMOSTRAS strobed samples and presents their truncated average.
module media_amostras
    import controlo_pkg::*;
#(
    parameter int unsigned N_AMOSTRAS = 4
) (
    input  logic                 clk,
    input  logic                 strobe,
    input  logic [LARG_PESO-1:0] amostra,
    input  logic                 clear,
    output logic [LARG_PESO-1:0] media,
    output logic                 done
);
    localparam int unsigned LOG_N     = $clog2(N_AMOSTRAS);
    localparam int unsigned LARG_SOMA = LARG_PESO + LOG_N;
    localparam int unsigned LARG_CONT = LOG_N + 1;
    localparam logic [LARG_CONT-1:0] ULTIMA = LARG_CONT'(N_AMOSTRAS - 1);

    logic [LARG_SOMA-1:0] soma_q, soma_d;
    logic [LARG_CONT-1:0] cont_q, cont_d;

    always_comb begin
        soma_d = soma_q;
        cont_d = cont_q;
        if (clear) begin
            soma_d = '0;
            cont_d = '0;
        end else if (strobe) begin
            soma_d = soma_q + LARG_SOMA'(amostra);
            cont_d = cont_q + LARG_CONT'(1);
        end
    end

    always_ff @(posedge clk) begin
        soma_q <= soma_d;
        cont_q <= cont_d;
    end

    // done flags the strobe that completes the window, so the FSM leaves ACUMULA on that edge
    assign media = LARG_PESO'(soma_q >> LOG_N);
    assign done  = strobe && (cont_q == ULTIMA);

endmodule

// File: rtl/controlo_pesagem.sv
// Weighing controller: averages load-cell samples, publishes net weight, overload and stability flags.
// Tare support is compiled in when the macro TARA_EN is defined.
module controlo_pesagem
    import controlo_pkg::*;
#(
    parameter int unsigned N_AMOSTRAS = 4,
    parameter int unsigned LIMITE_G   = LIMITE_G_DEF,
    parameter int unsigned JANELA_EST = JANELA_EST_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 amostra_valida,
    input  logic [LARG_PESO-1:0] amostra,
    input  logic                 botao_tara,
    output logic [LARG_PESO-1:0] gramas,
    output logic                 peso_valido,
    output logic                 sobrecarga,
    output logic                 estavel
);
    estado_t              estado_q, estado_d;
    logic [LARG_PESO-1:0] media;
    logic [LARG_PESO-1:0] gramas_q, gramas_d;
    logic [LARG_PESO-1:0] media_ant_q, media_ant_d;
    logic                 peso_valido_q, peso_valido_d;
    logic                 sobrecarga_q, sobrecarga_d;
    logic                 estavel_q, estavel_d;
    logic                 tem_ant_q, tem_ant_d;
    logic                 amostra_aceite, limpa, janela_cheia;
    logic                 acima_limite, dentro_janela;

`ifdef TARA_EN
    logic [LARG_PESO-1:0] tara_q, tara_d;
    logic                 tara_pend_q, tara_pend_d;
`else
    logic                 unused_tara;
    assign unused_tara = botao_tara;
`endif

    assign amostra_aceite = amostra_valida && !rst && (estado_q == ACUMULA);
    assign limpa          = rst || (estado_q == DIVIDE);

    media_amostras #(
        .N_AMOSTRAS(N_AMOSTRAS)
    ) u_media (
        .clk    (clk),
        .strobe (amostra_aceite),
        .amostra(amostra),
        .clear  (limpa),
        .media  (media),
        .done   (janela_cheia)
    );

    assign acima_limite  = 32'(media) > LIMITE_G;
    assign dentro_janela = 32'(dif_abs(media, media_ant_q)) <= JANELA_EST;

    always_ff @(posedge clk) begin
        if (rst) estado_q <= ACUMULA;
        else     estado_q <= estado_d;
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ACUMULA: if (janela_cheia) estado_d = DIVIDE;
            DIVIDE:  estado_d = PUBLICA;
            PUBLICA: estado_d = ACUMULA;
            default: estado_d = ACUMULA;
        endcase
    end

    // Results are registered on the edge leaving DIVIDE so they are visible throughout PUBLICA
    always_comb begin
        gramas_d      = gramas_q;
        peso_valido_d = 1'b0;
        sobrecarga_d  = sobrecarga_q;
        estavel_d     = estavel_q;
        media_ant_d   = media_ant_q;
        tem_ant_d     = tem_ant_q;
`ifdef TARA_EN
        tara_d        = tara_q;
        tara_pend_d   = tara_pend_q | botao_tara;
`endif
        if (estado_q == DIVIDE) begin
            peso_valido_d = 1'b1;
            estavel_d     = tem_ant_q && dentro_janela;
            media_ant_d   = media;
            tem_ant_d     = 1'b1;
            if (acima_limite) begin
                sobrecarga_d = 1'b1;
`ifdef TARA_EN
                tara_pend_d  = 1'b0;
`endif
            end else begin
                sobrecarga_d = 1'b0;
`ifdef TARA_EN
                tara_pend_d  = 1'b0;
                if (tara_pend_q || botao_tara) begin
                    tara_d   = media;
                    gramas_d = '0;
                end else begin
                    gramas_d = (media > tara_q) ? (media - tara_q) : '0;
                end
`else
                gramas_d = media;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gramas_q      <= '0;
            peso_valido_q <= 1'b0;
            sobrecarga_q  <= 1'b0;
            estavel_q     <= 1'b0;
            media_ant_q   <= '0;
            tem_ant_q     <= 1'b0;
        end else begin
            gramas_q      <= gramas_d;
            peso_valido_q <= peso_valido_d;
            sobrecarga_q  <= sobrecarga_d;
            estavel_q     <= estavel_d;
            media_ant_q   <= media_ant_d;
            tem_ant_q     <= tem_ant_d;
        end
    end

`ifdef TARA_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tara_q      <= '0;
            tara_pend_q <= 1'b0;
        end else begin
            tara_q      <= tara_d;
            tara_pend_q <= tara_pend_d;
        end
    end
`endif

    assign gramas      = gramas_q;
    assign peso_valido = peso_valido_q;
    assign sobrecarga  = sobrecarga_q;
    assign estavel     = estavel_q;

endmodule

// File: tb/tb_controlo_pesagem.sv
// Self-checking bench for controlo_pesagem: directed scenarios plus randomized traffic against a window-level model.
module tb_controlo_pesagem;
    localparam int N   = 4;
    localparam int LIM = 4000;
    localparam int JAN = 8;
`ifdef TARA_EN
    localparam bit TARA_ON = 1'b1;
`else
    localparam bit TARA_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, amostra_valida, botao_tara;
    logic [11:0] amostra, gramas;
    logic        peso_valido, sobrecarga, estavel;

    always #5 clk = ~clk;

    controlo_pesagem #(
        .N_AMOSTRAS(N),
        .LIMITE_G  (LIM),
        .JANELA_EST(JAN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .amostra_valida(amostra_valida),
        .amostra       (amostra),
        .botao_tara    (botao_tara),
        .gramas        (gramas),
        .peso_valido   (peso_valido),
        .sobrecarga    (sobrecarga),
        .estavel       (estavel)
    );

    int erros  = 0;
    int checks = 0;

    // Reference model: accepted samples queue, dead cycles after a full window, tare and history.
    int q[$];
    int morto;
    int m_media, m_tara, m_ant;
    bit m_tem_ant, m_pend;
    int e_gramas;
    bit e_pv, e_sob, e_est;

    task automatic modelo_reset();
        q.delete();
        morto = 0; m_media = 0; m_tara = 0; m_ant = 0;
        m_tem_ant = 0; m_pend = 0;
        e_gramas = 0; e_pv = 0; e_sob = 0; e_est = 0;
    endtask

    task automatic publica(input int m, input bit tp);
        int d;
        e_pv = 1;
        d = m - m_ant;
        if (d < 0) d = -d;
        e_est = m_tem_ant && (d <= JAN);
        m_ant = m;
        m_tem_ant = 1;
        if (m > LIM) begin
            e_sob = 1;
        end else begin
            e_sob = 0;
            if (TARA_ON && tp) begin
                m_tara = m;
                e_gramas = 0;
            end else begin
                e_gramas = (m > m_tara) ? m - m_tara : 0;
            end
        end
        m_pend = 0;
    endtask

    // One clock cycle: drive inputs, advance the model across the edge, settle past the edge.
    task automatic passo(input bit v, input int s, input bit t, input bit r);
        rst = r; amostra_valida = v; amostra = 12'(s); botao_tara = t;
        @(posedge clk);
        e_pv = 0;
        if (r) begin
            modelo_reset();
        end else if (morto == 2) begin
            publica(m_media, m_pend | t);
            morto = 1;
        end else if (morto == 1) begin
            morto = 0;
            if (t) m_pend = 1;
        end else begin
            if (t) m_pend = 1;
            if (v) begin
                q.push_back(s);
                if (q.size() == N) begin
                    int soma;
                    soma = 0;
                    foreach (q[i]) soma += q[i];
                    m_media = soma / N;
                    q.delete();
                    morto = 2;
                end
            end
        end
        #1;
    endtask

    // Idle cycle, N back-to-back strobes of v, then wait (bounded) for peso_valido.
    // lat counts cycles from the last strobe's cycle to the cycle where peso_valido is seen.
    task automatic janela(input int v, output int lat);
        passo(0, 0, 0, 0);
        for (int i = 0; i < N; i++) passo(1, v, 0, 0);
        lat = 1;
        while (!peso_valido && lat < 8) begin
            passo(0, 0, 0, 0);
            lat++;
        end
    endtask

    task automatic test_reset();
        passo(1, 1234, 1, 1);
        passo(0, 0, 0, 1);
        checks++; if (gramas !== 12'd0) begin erros++; $display("FAIL reset_gramas: got %0d expected 0", gramas); end
        checks++; if (peso_valido !== 1'b0) begin erros++; $display("FAIL reset_peso_valido: got %0b expected 0", peso_valido); end
        checks++; if (sobrecarga !== 1'b0) begin erros++; $display("FAIL reset_sobrecarga: got %0b expected 0", sobrecarga); end
        checks++; if (estavel !== 1'b0) begin erros++; $display("FAIL reset_estavel: got %0b expected 0", estavel); end
    endtask

    task automatic test_media_basica();
        int lat;
        passo(0, 0, 0, 1);
        janela(1040, lat);
        checks++; if (lat != 2) begin erros++; $display("FAIL basic_latency: got %0d expected 2", lat); end
        checks++; if (gramas !== 12'd1040) begin erros++; $display("FAIL basic_gramas: got %0d expected 1040", gramas); end
        checks++; if (sobrecarga !== 1'b0) begin erros++; $display("FAIL basic_sobrecarga: got %0b expected 0", sobrecarga); end
        checks++; if (estavel !== 1'b0) begin erros++; $display("FAIL basic_first_estavel: got %0b expected 0", estavel); end
        passo(0, 0, 0, 0);
        checks++; if (peso_valido !== 1'b0) begin erros++; $display("FAIL basic_pulse_width: got %0b expected 0", peso_valido); end
        janela(1044, lat);
        checks++; if (gramas !== 12'd1044) begin erros++; $display("FAIL stable_gramas: got %0d expected 1044", gramas); end
        checks++; if (estavel !== 1'b1) begin erros++; $display("FAIL stable_estavel: got %0b expected 1", estavel); end
        janela(1100, lat);
        checks++; if (gramas !== 12'd1100) begin erros++; $display("FAIL unstable_gramas: got %0d expected 1100", gramas); end
        checks++; if (estavel !== 1'b0) begin erros++; $display("FAIL unstable_estavel: got %0b expected 0", estavel); end
    endtask

    task automatic test_tara();
        int lat;
        int vals[6] = '{500, 500, 750, 400, 900, 1000};
        int esp[6];
        esp = TARA_ON ? '{500, 0, 250, 0, 0, 100} : vals;
        passo(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            janela(vals[i], lat);
            checks++;
            if (gramas !== 12'(esp[i])) begin
                erros++; $display("FAIL tare_window%0d: got %0d expected %0d", i, gramas, esp[i]);
            end
            // first press lands in ACUMULA; second press coincides with PUBLICA
            if (i == 0) begin
                passo(0, 0, 0, 0);
                passo(0, 0, 1, 0);
            end else if (i == 3) begin
                passo(0, 0, 1, 0);
            end
        end
    endtask

    task automatic test_sobrecarga();
        int lat;
        passo(0, 0, 0, 1);
        janela(1000, lat);
        janela(4095, lat);
        checks++; if (lat != 2) begin erros++; $display("FAIL overload_latency: got %0d expected 2", lat); end
        checks++; if (sobrecarga !== 1'b1) begin erros++; $display("FAIL overload_flag: got %0b expected 1", sobrecarga); end
        checks++; if (gramas !== 12'd1000) begin erros++; $display("FAIL overload_hold: got %0d expected 1000", gramas); end
        passo(0, 0, 0, 0);
        passo(0, 0, 1, 0);
        janela(4095, lat);
        checks++; if (gramas !== 12'd1000) begin erros++; $display("FAIL overload_tare_hold: got %0d expected 1000", gramas); end
        janela(1200, lat);
        checks++; if (sobrecarga !== 1'b0) begin erros++; $display("FAIL overload_clear: got %0b expected 0", sobrecarga); end
        checks++; if (gramas !== 12'd1200) begin erros++; $display("FAIL overload_tare_discarded: got %0d expected 1200", gramas); end
    endtask

    task automatic test_reset_parcial();
        int lat;
        passo(0, 0, 0, 1);
        passo(0, 0, 0, 0);
        passo(1, 1000, 0, 0);
        passo(1, 1000, 0, 0);
        passo(1, 1000, 0, 1);
        janela(200, lat);
        checks++; if (lat != 2) begin erros++; $display("FAIL partial_latency: got %0d expected 2", lat); end
        checks++; if (gramas !== 12'd200) begin erros++; $display("FAIL partial_gramas: got %0d expected 200", gramas); end
    endtask

    task automatic test_descarta();
        passo(0, 0, 0, 1);
        passo(0, 0, 0, 0);
        for (int i = 0; i < N; i++) passo(1, 800, 0, 0);
        passo(1, 3000, 0, 0);
        checks++; if (peso_valido !== 1'b1) begin erros++; $display("FAIL discard_pulse: got %0b expected 1", peso_valido); end
        checks++; if (gramas !== 12'd800) begin erros++; $display("FAIL discard_first_gramas: got %0d expected 800", gramas); end
        passo(1, 3000, 0, 0);
        for (int i = 0; i < N - 1; i++) passo(1, 600, 0, 0);
        for (int i = 0; i < 3; i++) begin
            passo(0, 0, 0, 0);
            checks++; if (peso_valido !== 1'b0) begin erros++; $display("FAIL discard_early_pulse%0d: got %0b expected 0", i, peso_valido); end
        end
        passo(1, 600, 0, 0);
        passo(0, 0, 0, 0);
        checks++; if (peso_valido !== 1'b1) begin erros++; $display("FAIL discard_late_pulse: got %0b expected 1", peso_valido); end
        checks++; if (gramas !== 12'd600) begin erros++; $display("FAIL discard_gramas: got %0d expected 600", gramas); end
    endtask

    task automatic test_aleatorio();
        int base, s, dens;
        bit v, t, r;
        base = 1500;
        passo(0, 0, 0, 1);
        for (int c = 0; c < 800; c++) begin
            dens = (c < 400) ? 50 : 100;
            if ($urandom_range(0, 49) == 0) base = $urandom_range(0, 4095);
            s = base + $urandom_range(0, 10);
            if (s > 4095) s = 4095;
            v = ($urandom_range(0, 99) < dens);
            t = ($urandom_range(0, 29) == 0);
            r = ($urandom_range(0, 299) == 0);
            passo(v, s, t, r);
            checks++; if (gramas !== 12'(e_gramas)) begin erros++; $display("FAIL rand_gramas@%0d: got %0d expected %0d", c, gramas, e_gramas); end
            checks++; if (peso_valido !== e_pv) begin erros++; $display("FAIL rand_peso_valido@%0d: got %0b expected %0b", c, peso_valido, e_pv); end
            checks++; if (sobrecarga !== e_sob) begin erros++; $display("FAIL rand_sobrecarga@%0d: got %0b expected %0b", c, sobrecarga, e_sob); end
            checks++; if (estavel !== e_est) begin erros++; $display("FAIL rand_estavel@%0d: got %0b expected %0b", c, estavel, e_est); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        modelo_reset();
        test_reset();
        test_media_basica();
        test_tara();
        test_sobrecarga();
        test_reset_parcial();
        test_descarta();
        test_aleatorio();
        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule

// File: doc/controlo_pesagem.md
CONTROLO_PESAGEM -- requirements
Module: controlo_pesagem

Interface
REQ-001 SHALL have parameter N_AMOSTRAS, default 4, samples averaged per measurement (power of two, 2..16).
REQ-002 SHALL have parameter LIMITE_G, default 4000, overload threshold in grams.
REQ-003 SHALL have parameter JANELA_EST, default 8, stability tolerance in grams.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port amostra_valida  in  1  one-cycle strobe, new raw sample present.
REQ-007 SHALL have port amostra  in  12  raw load-cell reading in grams, unsigned.
REQ-008 SHALL have port botao_tara  in  1  one-cycle tare request, already debounced.
REQ-009 SHALL have port gramas  out  12  registered net weight, feeds the kg/gram display converter.
REQ-010 SHALL have port peso_valido  out  1  one-cycle pulse when gramas updates.
REQ-011 SHALL have port sobrecarga  out  1  level, last average exceeded LIMITE_G.
REQ-012 SHALL have port estavel  out  1  level, last two averages within JANELA_EST.

Function
REQ-013 SHALL implement FSM states ACUMULA, DIVIDE, PUBLICA; reset state ACUMULA.
REQ-014 ACUMULA SHALL add each strobed amostra into a sum of width 12+log2(N_AMOSTRAS) and count strobes; after the N_AMOSTRAS-th strobe it SHALL go to DIVIDE.
REQ-015 DIVIDE SHALL form media = sum >> log2(N_AMOSTRAS) (truncating), clear sum and count, and go to PUBLICA.
REQ-016 PUBLICA SHALL update outputs and return to ACUMULA; it lasts exactly one cycle.
REQ-017 Latency: peso_valido SHALL assert exactly 2 cycles after the cycle of the N_AMOSTRAS-th strobe.
REQ-018 Strobes arriving in DIVIDE or PUBLICA SHALL be discarded, not counted.
REQ-019 Net = media - tara; if media < tara, gramas SHALL saturate to 0 (no wrap-around).
REQ-020 If media > LIMITE_G, PUBLICA SHALL set sobrecarga=1, hold gramas, and still pulse peso_valido; otherwise it SHALL clear sobrecarga.
REQ-021 estavel SHALL be 1 when |media - media_anterior| <= JANELA_EST; media_anterior SHALL update every PUBLICA; the first measurement after reset SHALL give estavel=0.
REQ-022 A tare press in any state SHALL be latched; it SHALL be consumed at the next PUBLICA, where tara <= media and gramas <= 0.
REQ-023 A latched tare consumed at a PUBLICA with sobrecarga SHALL be discarded and tara SHALL be unchanged.
REQ-024 A tare press coincident with PUBLICA SHALL be applied at the following PUBLICA.

Reset
REQ-025 rst SHALL force state ACUMULA, sum=0, count=0, tara=0, tare latch=0, media_anterior=0, gramas=0, peso_valido=0, sobrecarga=0, estavel=0.
REQ-026 rst mid-accumulation SHALL discard partial sum; a strobe in the same cycle as rst SHALL be ignored.

Configuration
REQ-027 Macro TARA_EN: when defined, REQ-022..024 apply.
REQ-028 Without TARA_EN, botao_tara SHALL be ignored, tara SHALL be constant 0, and gramas SHALL equal media when not in overload.

Structure
REQ-029 Shared package controlo_pkg SHALL hold the state enum, the 12-bit weight width constant and the default LIMITE_G/JANELA_EST values.
REQ-030 The accumulate/divide datapath SHALL be a sub-module media_amostras (inputs: strobe, sample, clear; outputs: media, done); the FSM, tare and flags stay in controlo_pesagem.

Verification
REQ-031 Four strobes of 1040, default params -> gramas=1040, peso_valido pulse 2 cycles after 4th strobe, sobrecarga=0, estavel=0.
REQ-032 Second window 1044,1044,1044,1044 -> gramas=1044, estavel=1; third window 1100 x4 -> estavel=0.
REQ-033 TARA_EN: media 500, tare press, next window 500 x4 -> gramas=0; next window 750 x4 -> gramas=250; next 400 x4 -> gramas=0 (saturation).
REQ-034 Window 4095 x4 -> sobrecarga=1, gramas holds previous value, peso_valido pulses; tare press then -> tara unchanged.
REQ-035 Two strobes of 1000 then rst, then 200 x4 -> gramas=200 (partial sum discarded).
REQ-036 Strobe in DIVIDE cycle -> not counted; window completes only after 4 further ACUMULA strobes.
